// File: rtl/inst_encoder_if.sv
// Field-bundle handshake and instruction-memory write port of the instruction encoder.
// The encoder uses the slave view; the producer / memory side uses the master view.
interface inst_encoder_if;
  logic        valid_i;
  logic        ready_o;
  logic        kind_i;
  logic [4:0]  rs_i;
  logic [4:0]  rt_i;
  logic [4:0]  rd_i;
  logic [4:0]  shamt_i;
  logic [5:0]  funct_i;
  logic [15:0] imm_i;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_ack_i;

  modport slave (
    input  valid_i, kind_i, rs_i, rt_i, rd_i, shamt_i, funct_i, imm_i, mem_ack_i,
    output ready_o, mem_we_o, mem_addr_o, mem_data_o
  );

  modport master (
    output valid_i, kind_i, rs_i, rt_i, rd_i, shamt_i, funct_i, imm_i, mem_ack_i,
    input  ready_o, mem_we_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/inst_encoder.sv
// Packs R-type / addi field bundles into MIPS words, buffers them in a FIFO and
// streams them into instruction memory at sequential word addresses.
module inst_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          MEM_WORDS = 256
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  inst_encoder_if.slave              bus,
  input  logic                       flush_i,
  output logic                       done_o,
  output logic                       halt_o,
  output logic [$clog2(MEM_WORDS):0] words_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(MEM_WORDS) + 1;

  typedef enum logic [1:0] {IDLE, WRITE, HALT} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fifo_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic [WW-1:0]   words_q, words_d;
  logic            done_q, done_d;
  logic            full, push, pop;
  logic [31:0]     push_word, next_word;

  always_comb begin
    if (bus.kind_i) push_word = {6'b001000, bus.rs_i, bus.rt_i, bus.imm_i};
    else            push_word = {6'b000000, bus.rs_i, bus.rt_i, bus.rd_i, bus.shamt_i, bus.funct_i};
  end

  // The word on the memory port is still the FIFO head, so it counts toward full.
  assign full        = (count_q == CW'(DEPTH));
  assign bus.ready_o = rst_i && !full && (state_q != HALT);
  assign push        = bus.valid_i && bus.ready_o;
  assign pop         = (state_q == WRITE) && bus.mem_ack_i;

  // Word following the head: from the FIFO if queued, else the one arriving now.
  assign next_word = (count_q > CW'(1)) ? fifo_q[rd_ptr_q + AW'(1)] : push_word;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    words_d = words_q;
    count_d = count_q + CW'(push) - CW'(pop);
    done_d  = flush_i && (count_q == '0) && (state_q == IDLE) && !push;
    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          data_d  = fifo_q[rd_ptr_q];
          state_d = WRITE;
        end
      end
      WRITE: begin
        if (bus.mem_ack_i) begin
          addr_d  = addr_q + 32'd4;
          words_d = words_q + WW'(1);
          if (words_d == WW'(MEM_WORDS)) state_d = HALT;
          else if ((count_q > CW'(1)) || push) data_d = next_word;
          else state_d = IDLE;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the FIFO storage has no reset; the pointers and count alone define
  // which entries are valid, so clearing the array would buy nothing.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= push_word;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= BASE_ADDR;
      data_q   <= '0;
      words_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      words_q  <= words_d;
      done_q   <= done_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  assign bus.mem_we_o   = (state_q == WRITE);
  assign bus.mem_addr_o = addr_q;
  assign bus.mem_data_o = data_q;
  assign done_o         = done_q;
  assign halt_o         = (state_q == HALT);
  assign words_o        = words_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: a queue-based model checked every cycle,
// plus directed scenarios pinned with hand-computed literal expectations.
module tb_inst_encoder;
  localparam int          DEPTH     = 4;
  localparam logic [31:0] BASE_ADDR = 32'h0;
  localparam int          MEM_WORDS = 256;

  logic       clk;
  logic       rst_i;
  logic       flush;
  logic       done;
  logic       halt;
  logic [8:0] words;

  inst_encoder_if bus();

  inst_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR), .MEM_WORDS(MEM_WORDS)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .bus     (bus),
    .flush_i (flush),
    .done_o  (done),
    .halt_o  (halt),
    .words_o (words)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] encode(input logic kind, input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn, input logic [15:0] imm);
    int unsigned w;
    if (kind) w = 32'h2000_0000 + rs * 32'h20_0000 + rt * 32'h1_0000 + imm;
    else      w = rs * 32'h20_0000 + rt * 32'h1_0000 + rd * 32'h800 + sh * 32'h40 + fn;
    return w;
  endfunction

  // Model: queue of words not yet retired (head = word on the port when busy).
  logic [31:0] m_q[$];
  int          m_words;
  bit          m_busy, m_halted, m_done;
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  always @(negedge clk) begin
    bit m_ready, m_push, m_pop;
    int pre;
    if (!rst_i) begin
      check("rst_we",    bus.mem_we_o,   0);
      check("rst_addr",  bus.mem_addr_o, BASE_ADDR);
      check("rst_data",  bus.mem_data_o, 0);
      check("rst_ready", bus.ready_o,    0);
      check("rst_done",  done,           0);
      check("rst_halt",  halt,           0);
      check("rst_words", words,          0);
      m_q.delete();
      m_words = 0; m_busy = 0; m_halted = 0; m_done = 0;
    end else begin
      m_ready = (m_q.size() < DEPTH) && !m_halted;
      check("we", bus.mem_we_o, m_busy);
      if (m_busy) begin
        check("addr", bus.mem_addr_o, BASE_ADDR + 32'(4 * m_words));
        check("data", bus.mem_data_o, m_q[0]);
      end
      check("ready", bus.ready_o, m_ready);
      check("done",  done,        m_done);
      check("halt",  halt,        m_halted);
      check("words", words,       m_words);
      m_push = bus.valid_i && m_ready;
      m_pop  = m_busy && bus.mem_ack_i;
      pre    = m_q.size();
      m_done = flush && (pre == 0) && !m_busy && !m_halted && !m_push;
      if (m_pop) begin
        log_addr.push_back(bus.mem_addr_o);
        log_data.push_back(bus.mem_data_o);
        void'(m_q.pop_front());
        m_words++;
      end
      if (m_push)
        m_q.push_back(encode(bus.kind_i, bus.rs_i, bus.rt_i, bus.rd_i, bus.shamt_i, bus.funct_i, bus.imm_i));
      if (m_halted) m_busy = 0;
      else if (m_pop) begin
        if (m_words == MEM_WORDS) begin m_halted = 1; m_busy = 0; end
        else m_busy = (m_q.size() > 0);
      end else if (!m_busy) m_busy = (pre > 0);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic kind, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic [4:0] sh, input logic [5:0] fn, input logic [15:0] imm,
                      input int tmo, input bit must, output bit ok);
    int n = 0;
    bus.kind_i = kind; bus.rs_i = rs; bus.rt_i = rt; bus.rd_i = rd;
    bus.shamt_i = sh; bus.funct_i = fn; bus.imm_i = imm; bus.valid_i = 1'b1;
    while (!bus.ready_o && n < tmo) begin step(); n++; end
    ok = bus.ready_o;
    if (must) check("send_accept", ok, 1);
    step();
    bus.valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((m_q.size() != 0 || m_busy) && n < 200) begin step(); n++; end
    check("idle_timeout", (n < 200), 1);
    step();
  endtask

  initial begin
    bit ok;
    int n;
    logic [31:0] hold_addr, hold_data;
    rst_i = 1'b0; flush = 1'b0;
    bus.valid_i = 0; bus.kind_i = 0; bus.rs_i = 0; bus.rt_i = 0; bus.rd_i = 0;
    bus.shamt_i = 0; bus.funct_i = 0; bus.imm_i = 0; bus.mem_ack_i = 0;
    repeat (3) step();
    rst_i = 1'b1;
    step();

    // R-type then addi, immediate acks
    bus.mem_ack_i = 1'b1;
    send(0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 50, 1, ok);
    send(1, 5'd0, 5'd1, 5'd9, 5'd4, 6'h3f, 16'd5, 50, 1, ok);
    wait_idle();
    check("t1_addr0", log_addr[0], 32'h0);
    check("t1_data0", log_data[0], 32'h0022_1820);
    check("t1_addr1", log_addr[1], 32'h4);
    check("t1_data1", log_data[1], 32'h2001_0005);
    check("t1_words", words, 2);

    // Backpressure: 4 fill the FIFO with ack held low, 5th waits
    bus.mem_ack_i = 1'b0;
    for (int i = 0; i < 4; i++)
      send(i[0], 5'(i + 4), 5'(i + 8), 5'(i + 12), 5'(i), 6'(i + 32), 16'(16'h1000 + i), 50, 1, ok);
    fork
      send(1, 5'd31, 5'd30, 5'd7, 5'd3, 6'h3f, 16'hffff, 50, 1, ok);
      begin
        repeat (3) step();
        check("t2_full_ready", bus.ready_o, 0);
        check("t2_full_we", bus.mem_we_o, 1);
        bus.mem_ack_i = 1'b1;
      end
    join
    wait_idle();
    check("t2_addr5", log_addr[6], 32'h18);
    check("t2_data5", log_data[6], 32'h23fe_ffff);
    check("t2_words", words, 7);

    // Ack delayed three cycles: port held stable, one increment
    bus.mem_ack_i = 1'b0;
    send(0, 5'd5, 5'd6, 5'd7, 5'd8, 6'h2a, 16'h0, 50, 1, ok);
    n = 0;
    while (!bus.mem_we_o && n < 20) begin step(); n++; end
    check("t3_we_timeout", (n < 20), 1);
    for (int i = 0; i < 3; i++) begin
      check("t3_hold_addr", bus.mem_addr_o, 32'h1c);
      check("t3_hold_data", bus.mem_data_o, 32'h00a6_3a2a);
      step();
    end
    check("t3_hold_addr", bus.mem_addr_o, 32'h1c);
    bus.mem_ack_i = 1'b1;
    step();
    bus.mem_ack_i = 1'b0;
    check("t3_words", words, 8);
    check("t3_we_off", bus.mem_we_o, 0);
    check("t3_next_addr", bus.mem_addr_o, 32'h20);

    // Flush with two words queued
    send(0, 5'd9, 5'd10, 5'd11, 5'd0, 6'h22, 16'h0, 50, 1, ok);
    send(1, 5'd2, 5'd3, 5'd0, 5'd0, 6'h00, 16'h8000, 50, 1, ok);
    flush = 1'b1;
    repeat (3) step();
    check("t5_done_early", done, 0);
    bus.mem_ack_i = 1'b1;
    wait_idle();
    step();
    check("t5_done", done, 1);
    check("t5_words", words, 10);
    flush = 1'b0;
    step();
    check("t5_done_clear", done, 0);

    // Fill to capacity: halt after MEM_WORDS writes
    for (int i = 0; i < 300; i++) begin
      send(i[1], 5'(i), 5'(i >> 2), 5'(i + 1), 5'(i + 2), 6'(i), 16'(i * 3), 20, 0, ok);
      if (!ok) break;
    end
    n = 0;
    while (!halt && n < 50) begin step(); n++; end
    check("t4_halt_timeout", (n < 50), 1);
    bus.valid_i = 1'b1;
    repeat (10) step();
    bus.valid_i = 1'b0;
    check("t4_halt", halt, 1);
    check("t4_words", words, 256);
    check("t4_we", bus.mem_we_o, 0);
    check("t4_ready", bus.ready_o, 0);
    check("t4_writes", log_addr.size(), 256);
    check("t4_last_addr", log_addr[255], 32'h3fc);

    rst_i = 1'b0;
    repeat (2) step();
    rst_i = 1'b1;
    step();

    // Reset in the middle of a write with three words queued
    bus.mem_ack_i = 1'b0;
    for (int i = 0; i < 3; i++)
      send(0, 5'(i), 5'(i), 5'(i), 5'(i), 6'(i), 16'h0, 50, 1, ok);
    check("t6_we_before", bus.mem_we_o, 1);
    rst_i = 1'b0;
    #1;
    check("t6_we_async", bus.mem_we_o, 0);
    step();
    rst_i = 1'b1;
    #1;
    check("t6_ready", bus.ready_o, 1);
    check("t6_words", words, 0);
    check("t6_addr", bus.mem_addr_o, 32'h0);
    repeat (4) step();
    check("t6_no_write", bus.mem_we_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
Encoder counterpart of the single-cycle CPU's opcode decoder (Control). It accepts decoded instruction fields (R-type, or I-type addi) over a valid/ready handshake and packs them into 32-bit MIPS words. Words are buffered in a small FIFO and streamed into instruction memory at sequential word addresses. The bench and the boot loader use it to fill instruction memory before the CPU's start signal.

Parameters:
DEPTH, 4, FIFO entries (power of two, at least 2)
BASE_ADDR, 32'h0, byte address of the first instruction written
MEM_WORDS, 256, instruction memory capacity in words; writing stops after this many

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous active-low reset
valid_i  input  1  field bundle valid
ready_o  output  1  encoder can accept a bundle
kind_i  input  1  0 = R-type (opcode 000000), 1 = addi (opcode 001000)
rs_i  input  5  source register
rt_i  input  5  target register
rd_i  input  5  destination register (R-type only)
shamt_i  input  5  shift amount (R-type only)
funct_i  input  6  function code (R-type only)
imm_i  input  16  immediate (addi only)
mem_we_o  output  1  instruction memory write request
mem_addr_o  output  32  byte address of the write
mem_data_o  output  32  encoded instruction word
mem_ack_i  input  1  memory has taken the current write
flush_i  input  1  no more bundles will be sent (level)
done_o  output  1  flush requested and all words written
halt_o  output  1  MEM_WORDS words written, encoder stopped
words_o  output  9  number of words acknowledged (width clog2(MEM_WORDS)+1)

Behaviour:
- Reset (rst_i low, asynchronous):
  - FIFO empty; address register = BASE_ADDR; state = IDLE.
  - mem_we_o, mem_addr_o (= BASE_ADDR), mem_data_o, done_o, halt_o, words_o, ready_o all drive 0.
- After reset release: ready_o = !fifo_full && state != HALT, decoded from registered state only. There is no combinational path from valid_i or mem_ack_i to ready_o.
- Accept and encode:
  - A bundle is accepted on a clock edge where valid_i && ready_o.
  - R-type encodes as {6'b000000, rs, rt, rd, shamt, funct}.
  - addi encodes as {6'b001000, rs, rt, imm}; rd, shamt and funct are ignored.
  - The encoded word is pushed into the FIFO in the same cycle it is accepted.
- State machine:
  - IDLE: mem_we_o = 0. If the FIFO is non-empty at a clock edge, register the head word and current address onto mem_data_o/mem_addr_o, set mem_we_o = 1, and go to WRITE.
  - WRITE: mem_we_o, mem_addr_o and mem_data_o are held stable until a cycle with mem_ack_i = 1. On that edge:
    - Pop the head, add 4 to the address, increment words_o.
    - If words_o reaches MEM_WORDS, go to HALT with mem_we_o = 0.
    - Else if another word is queued after the pop, stay in WRITE and present it the next cycle (back-to-back, one word per cycle while mem_ack_i stays high).
    - Otherwise go to IDLE with mem_we_o = 0.
  - HALT: halt_o = 1, ready_o = 0, mem_we_o = 0. Entries left in the FIFO are retained but never written. HALT is left only by reset.
- Latency: a bundle accepted on edge N appears on the memory port after edge N+1 at the earliest (FIFO empty, state IDLE).
- Timing of mem_ack_i:
  - mem_ack_i while mem_we_o = 0 is ignored.
  - An ack in the first cycle of mem_we_o is legal and retires the word that cycle.
- Simultaneous push and pop in the same cycle: both take effect and the occupancy is unchanged.
- Full FIFO: ready_o is 0, so no push occurs. A pop in that cycle raises ready_o on the next cycle.
- Address wrap: the address never wraps, because HALT is entered after MEM_WORDS words.
- done_o is asserted (registered) when flush_i = 1, the FIFO is empty, state = IDLE and no bundle is being accepted. It follows flush_i low again.
- Reset mid-write: the in-flight word is abandoned and mem_we_o drops immediately (asynchronously).

Test Plan:
- R-type rs=1 rt=2 rd=3 shamt=0 funct=0x20, then addi rs=0 rt=1 imm=5, acks immediate → writes 0x00221820 @0x0 then 0x20010005 @0x4, words_o=2, ready_o never drops.
- Hold mem_ack_i=0, push 5 bundles (DEPTH=4) → ready_o=0 after 4 accepted (the head is held on the port and still counts as a FIFO entry); release ack → 4 writes on consecutive cycles; then the 5th bundle is accepted and written @0x10.
- mem_ack_i delayed 3 cycles on the first write → mem_addr_o/mem_data_o stable for all 4 cycles; exactly one address increment.
- MEM_WORDS=4, push 6 bundles with acks → 4 writes @0x0..0xC, halt_o=1, ready_o=0, mem_we_o=0, words_o=4, no further writes.
- flush_i=1 with 2 words queued → done_o stays 0 until the cycle after the 2nd ack, then 1; deassert flush_i → done_o=0.
- Assert rst_i low while mem_we_o=1 with 3 words queued → mem_we_o=0 immediately; after release FIFO is empty, mem_addr_o=BASE_ADDR, words_o=0, ready_o=1.
